status_reg: RTL and testbench
=============================

STATUS_REG -- requirements
Module: status_reg

Interface
REQ-001 SHALL have: clk  input  1  rising-edge clock for all state.
REQ-002 SHALL have: reset  input  1  synchronous, active-high; clock clk.
REQ-003 SHALL have: alu_c, alu_z, alu_v, alu_n  input  1 each  carry, zero, overflow and negative flags from the upstream ALU, sampled at clk.
REQ-004 SHALL have: ld_c_alu, ld_z_alu, ld_v_alu, ld_n_alu  input  1 each  per-flag load enables from ALU flags.
REQ-005 SHALL have: db_in  input  8  internal data bus value (pulled status byte, or loaded operand for N/Z).
REQ-006 SHALL have: ld_p_db  input  1  load whole P from db_in (pull status / return from interrupt).
REQ-007 SHALL have: ld_nz_db  input  1  load N=db_in[7], Z=(db_in==8'h00).
REQ-008 SHALL have: set_c, clr_c, set_i, clr_i, set_d, clr_d, clr_v  input  1 each  explicit flag set/clear strobes.
REQ-009 SHALL have: db_oe  input  1  drive P onto db_out; brk_push  input  1  value of the B bit in the pushed byte.
REQ-010 SHALL have: db_out  output  8  pushed status byte, high-impedance when db_oe=0.
REQ-011 SHALL have: br_req  input  1, br_sel  input  3  branch condition request; br_sel[1:0] selects flag (00 N, 01 V, 10 C, 11 Z), br_sel[2] is the required flag value.
REQ-012 SHALL have: br_taken  output  1  registered branch decision.
REQ-013 SHALL have: c_out  output  1  current C, feeds ALU carry-in; dec_en  output  1  current D, feeds ALU decimal enable.
REQ-014 SHALL have: irq_mask  output  1  interrupt mask seen by the interrupt logic.

Function
REQ-015 SHALL hold stored flags N,V,D,I,Z,C; byte layout bit7..0 = N,V,1,B,D,I,Z,C; bits 5 and 4 SHALL NOT be stored.
REQ-016 SHALL update flags only on the rising edge of clk; c_out and dec_en SHALL equal stored C and D combinationally from the register (no input-to-output path).
REQ-017 SHALL apply per-flag priority, highest first: reset, ld_p_db, set/clr strobe, ld_nz_db (N,Z only), ld_*_alu.
REQ-018 SHALL, on ld_p_db, load N,V,D,I,Z,C from db_in[7,6,3,2,1,0] and ignore db_in[5:4].
REQ-019 SHALL hold a flag unchanged when its set and clr strobes are both asserted in the same cycle; other flags update normally.
REQ-020 SHALL, with db_oe=1, drive db_out = {N,V,1,brk_push,D,I,Z,C} combinationally from current stored flags, reflecting pre-edge values in an update cycle.
REQ-021 SHALL set br_taken at clk when br_req=1 to (selected flag == br_sel[2]) using the flag value before that edge's update; br_taken SHALL be 0 after any edge with br_req=0.
REQ-022 SHALL register irq_mask from stored I each clock, so a change of I becomes visible on irq_mask one cycle after I changes (CLI/SEI/PLP latency).
REQ-023 SHALL treat all enables as independent; any combination SHALL produce defined flag values per REQ-017/019.

Reset
REQ-024 SHALL, on clk with reset=1, set I=1, N=V=D=Z=C=0, irq_mask=1, br_taken=0, overriding all other inputs.
REQ-025 SHALL, when reset is asserted mid-branch-request or mid-load, discard that operation entirely.

Verification
REQ-026 Reset then db_oe=1, brk_push=1 -> db_out=8'h34, irq_mask=1, br_taken=0, c_out=0, dec_en=0.
REQ-027 ld_p_db with db_in=8'hFF, then db_oe=1, brk_push=0 -> db_out=8'hEF; c_out=1, dec_en=1.
REQ-028 alu_c=1, alu_z=1, ld_c_alu=1, ld_z_alu=1 with clr_c=1 same cycle -> C=0, Z=1.
REQ-029 clr_i at edge k -> I=0 after edge k, irq_mask=0 only after edge k+1; set_i and clr_i together -> I unchanged.
REQ-030 Z=0, br_req=1, br_sel=3'b011 (BNE) in same cycle as ld_z_alu with alu_z=1 -> br_taken=1 (pre-update Z), Z=1 afterwards; next cycle br_req=0 -> br_taken=0.
REQ-031 ld_nz_db with db_in=8'h80 -> N=1, Z=0; db_in=8'h00 -> N=0, Z=1; reset asserted with ld_p_db=1, db_in=8'hFF -> reset values of REQ-024.

Source files
------------

// File: rtl/status_reg.sv
// status_reg -- processor status register (P) with flag update priority,
// branch-condition evaluation and interrupt-mask staging.
//
// Ports:
//   clk, reset                 rising-edge clock; synchronous active-high reset
//   alu_c/z/v/n, ld_*_alu      ALU flag values and their per-flag load enables
//   db_in, ld_p_db, ld_nz_db   data-bus byte; whole-P load; N/Z load from operand
//   set_/clr_ strobes          explicit C, I, D set/clear and V clear
//   db_oe, brk_push, db_out    pushed status byte, tri-stated when db_oe=0
//   br_req, br_sel, br_taken   branch test: flag select [1:0], wanted value [2]
//   c_out, dec_en              stored C and D straight from the register
//   irq_mask                   I delayed by one clock
module status_reg (
  input  logic       clk,
  input  logic       reset,
  input  logic       alu_c,
  input  logic       alu_z,
  input  logic       alu_v,
  input  logic       alu_n,
  input  logic       ld_c_alu,
  input  logic       ld_z_alu,
  input  logic       ld_v_alu,
  input  logic       ld_n_alu,
  input  logic [7:0] db_in,
  input  logic       ld_p_db,
  input  logic       ld_nz_db,
  input  logic       set_c,
  input  logic       clr_c,
  input  logic       set_i,
  input  logic       clr_i,
  input  logic       set_d,
  input  logic       clr_d,
  input  logic       clr_v,
  input  logic       db_oe,
  input  logic       brk_push,
  output logic [7:0] db_out,
  input  logic       br_req,
  input  logic [2:0] br_sel,
  output logic       br_taken,
  output logic       c_out,
  output logic       dec_en,
  output logic       irq_mask
);

  // Bits 5 and 4 of the byte are not storage: bit 5 always reads 1 and
  // bit 4 reflects brk_push at push time.
  logic n, v, d, i, z, c;
  logic sel_flag;

  always_comb begin
    sel_flag = 1'b0;
    case (br_sel[1:0])
      2'b00: sel_flag = n;
      2'b01: sel_flag = v;
      2'b10: sel_flag = c;
      2'b11: sel_flag = z;
      default: sel_flag = 1'b0;
    endcase
  end

  // Each flag resolves its own priority chain. A set/clr pair asserted
  // together still occupies the strobe level, so it holds the flag and
  // blocks the lower-priority ALU load.
  always_ff @(posedge clk) begin
    if (reset) begin
      n <= 1'b0;
      v <= 1'b0;
      d <= 1'b0;
      i <= 1'b1;
      z <= 1'b0;
      c <= 1'b0;
      irq_mask <= 1'b1;
      br_taken <= 1'b0;
    end else begin
      // Branch decision and mask staging use pre-edge flag values.
      br_taken <= br_req & (sel_flag == br_sel[2]);
      irq_mask <= i;

      if (ld_p_db)       n <= db_in[7];
      else if (ld_nz_db) n <= db_in[7];
      else if (ld_n_alu) n <= alu_n;

      if (ld_p_db)       z <= db_in[1];
      else if (ld_nz_db) z <= (db_in == 8'h00);
      else if (ld_z_alu) z <= alu_z;

      if (ld_p_db)       v <= db_in[6];
      else if (clr_v)    v <= 1'b0;
      else if (ld_v_alu) v <= alu_v;

      if (ld_p_db)              c <= db_in[0];
      else if (set_c & clr_c)   c <= c;
      else if (set_c)           c <= 1'b1;
      else if (clr_c)           c <= 1'b0;
      else if (ld_c_alu)        c <= alu_c;

      if (ld_p_db)              d <= db_in[3];
      else if (set_d & ~clr_d)  d <= 1'b1;
      else if (clr_d & ~set_d)  d <= 1'b0;

      if (ld_p_db)              i <= db_in[2];
      else if (set_i & ~clr_i)  i <= 1'b1;
      else if (clr_i & ~set_i)  i <= 1'b0;
    end
  end

  assign c_out  = c;
  assign dec_en = d;
  assign db_out = db_oe ? {n, v, 1'b1, brk_push, d, i, z, c} : 8'bz;

endmodule

// File: tb/tb_status_reg.sv
module tb_status_reg;
  logic clk = 1'b0;
  logic reset;
  logic alu_c, alu_z, alu_v, alu_n;
  logic ld_c_alu, ld_z_alu, ld_v_alu, ld_n_alu;
  logic [7:0] db_in;
  logic ld_p_db, ld_nz_db;
  logic set_c, clr_c, set_i, clr_i, set_d, clr_d, clr_v;
  logic db_oe, brk_push;
  wire  [7:0] db_out;
  logic br_req;
  logic [2:0] br_sel;
  logic br_taken, c_out, dec_en, irq_mask;

  int checks = 0;
  int errors = 0;

  status_reg dut (
    .clk(clk), .reset(reset),
    .alu_c(alu_c), .alu_z(alu_z), .alu_v(alu_v), .alu_n(alu_n),
    .ld_c_alu(ld_c_alu), .ld_z_alu(ld_z_alu), .ld_v_alu(ld_v_alu), .ld_n_alu(ld_n_alu),
    .db_in(db_in), .ld_p_db(ld_p_db), .ld_nz_db(ld_nz_db),
    .set_c(set_c), .clr_c(clr_c), .set_i(set_i), .clr_i(clr_i),
    .set_d(set_d), .clr_d(clr_d), .clr_v(clr_v),
    .db_oe(db_oe), .brk_push(brk_push), .db_out(db_out),
    .br_req(br_req), .br_sel(br_sel), .br_taken(br_taken),
    .c_out(c_out), .dec_en(dec_en), .irq_mask(irq_mask)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: flags kept as a 6-entry array indexed by name.
  localparam int FN = 0, FV = 1, FD = 2, FI = 3, FZ = 4, FC = 5;
  logic [5:0] mf;
  logic m_irq, m_br, m_valid = 1'b0;

  always @(posedge clk) begin
    logic [5:0] nf;
    logic [5:0] of;
    logic tst;
    of = mf;
    if (reset) begin
      mf <= 6'b0 | (6'b1 << FI);
      m_irq <= 1'b1;
      m_br <= 1'b0;
      m_valid <= 1'b1;
    end else if (m_valid) begin
      tst = (br_sel[1:0] == 2'd0) ? of[FN] : (br_sel[1:0] == 2'd1) ? of[FV] :
            (br_sel[1:0] == 2'd2) ? of[FC] : of[FZ];
      m_br <= br_req && (tst == br_sel[2]);
      m_irq <= of[FI];
      // Apply layers lowest priority first; later layers overwrite.
      nf = of;
      if (ld_n_alu) nf[FN] = alu_n;
      if (ld_z_alu) nf[FZ] = alu_z;
      if (ld_v_alu) nf[FV] = alu_v;
      if (ld_c_alu) nf[FC] = alu_c;
      if (ld_nz_db) begin nf[FN] = db_in[7]; nf[FZ] = (db_in == 0); end
      if (set_c || clr_c) nf[FC] = (set_c && clr_c) ? of[FC] : set_c;
      if (set_d != clr_d) nf[FD] = set_d;
      if (set_i != clr_i) nf[FI] = set_i;
      if (clr_v) nf[FV] = 1'b0;
      if (ld_p_db) begin
        nf[FN] = db_in[7]; nf[FV] = db_in[6]; nf[FD] = db_in[3];
        nf[FI] = db_in[2]; nf[FZ] = db_in[1]; nf[FC] = db_in[0];
      end
      mf <= nf;
    end
  end

  // Per-cycle compare against the model, once a reset has defined state.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("c_out", {7'b0, c_out}, {7'b0, mf[FC]});
      chk("dec_en", {7'b0, dec_en}, {7'b0, mf[FD]});
      chk("irq_mask", {7'b0, irq_mask}, {7'b0, m_irq});
      chk("br_taken", {7'b0, br_taken}, {7'b0, m_br});
      if (db_oe)
        chk("db_out", db_out, {mf[FN], mf[FV], 1'b1, brk_push, mf[FD], mf[FI], mf[FZ], mf[FC]});
    end
  end

  task automatic idle();
    reset = 0; {alu_c, alu_z, alu_v, alu_n} = 4'b0;
    {ld_c_alu, ld_z_alu, ld_v_alu, ld_n_alu} = 4'b0;
    db_in = 8'h00; ld_p_db = 0; ld_nz_db = 0;
    {set_c, clr_c, set_i, clr_i, set_d, clr_d, clr_v} = 7'b0;
    db_oe = 1; brk_push = 0; br_req = 0; br_sel = 3'b000;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  initial begin
    idle();
    reset = 1;
    tick(); tick();
    // Reset values on the pushed byte.
    idle(); brk_push = 1;
    @(negedge clk);
    chk("rst db_out", db_out, 8'h34);
    chk("rst irq", {7'b0, irq_mask}, 8'h01);
    chk("rst br", {7'b0, br_taken}, 8'h00);
    chk("rst c/d", {6'b0, c_out, dec_en}, 8'h00);
    // Whole-P load ignores bits 5:4.
    tick(); idle(); ld_p_db = 1; db_in = 8'hFF;
    tick(); idle();
    @(negedge clk);
    chk("plp FF", db_out, 8'hEF);
    chk("plp c/d", {6'b0, c_out, dec_en}, 8'h03);
    // Strobe beats ALU load on C; Z still loads.
    tick(); idle(); ld_p_db = 1; db_in = 8'h00;
    tick(); idle(); alu_c = 1; alu_z = 1; ld_c_alu = 1; ld_z_alu = 1; clr_c = 1;
    tick(); idle();
    @(negedge clk);
    chk("clr_c vs alu", db_out & 8'h03, 8'h02);
    // I / irq_mask latency.
    set_i = 1; tick(); idle(); tick();
    @(negedge clk);
    chk("sei irq", {7'b0, irq_mask}, 8'h01);
    tick(); clr_i = 1; tick(); idle();
    @(negedge clk);
    chk("cli I", db_out & 8'h04, 8'h00);
    chk("cli irq k", {7'b0, irq_mask}, 8'h01);
    tick();
    @(negedge clk);
    chk("cli irq k+1", {7'b0, irq_mask}, 8'h00);
    tick(); set_i = 1; clr_i = 1; tick(); idle();
    @(negedge clk);
    chk("set+clr i hold", db_out & 8'h04, 8'h00);
    // BNE with Z updated in the same cycle.
    tick(); ld_p_db = 1; db_in = 8'h00; tick(); idle();
    br_req = 1; br_sel = 3'b011; ld_z_alu = 1; alu_z = 1;
    tick(); idle();
    @(negedge clk);
    chk("bne taken", {7'b0, br_taken}, 8'h01);
    chk("bne z after", db_out & 8'h02, 8'h02);
    tick();
    @(negedge clk);
    chk("br idle", {7'b0, br_taken}, 8'h00);
    // N/Z from operand.
    ld_nz_db = 1; db_in = 8'h80; tick(); idle();
    @(negedge clk);
    chk("nz 80", db_out & 8'h82, 8'h80);
    ld_nz_db = 1; db_in = 8'h00; tick(); idle();
    @(negedge clk);
    chk("nz 00", db_out & 8'h82, 8'h02);
    // Reset overrides a concurrent load and branch.
    reset = 1; ld_p_db = 1; db_in = 8'hFF; br_req = 1; br_sel = 3'b111;
    tick(); idle();
    @(negedge clk);
    chk("rst over ld", db_out, 8'h24);
    chk("rst over br", {6'b0, br_taken, irq_mask}, 8'h01);

    // Randomized phase; the compare process checks every cycle.
    for (int k = 0; k < 3000; k++) begin
      reset = ($urandom_range(0, 59) == 0);
      {alu_c, alu_z, alu_v, alu_n} = 4'($urandom);
      ld_c_alu = ($urandom_range(0, 2) == 0); ld_z_alu = ($urandom_range(0, 2) == 0);
      ld_v_alu = ($urandom_range(0, 2) == 0); ld_n_alu = ($urandom_range(0, 2) == 0);
      db_in = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      ld_p_db = ($urandom_range(0, 7) == 0); ld_nz_db = ($urandom_range(0, 4) == 0);
      set_c = ($urandom_range(0, 3) == 0); clr_c = ($urandom_range(0, 3) == 0);
      set_i = ($urandom_range(0, 3) == 0); clr_i = ($urandom_range(0, 3) == 0);
      set_d = ($urandom_range(0, 3) == 0); clr_d = ($urandom_range(0, 3) == 0);
      clr_v = ($urandom_range(0, 4) == 0);
      db_oe = ($urandom_range(0, 3) != 0); brk_push = 1'($urandom);
      br_req = 1'($urandom); br_sel = 3'($urandom);
      tick();
    end
    idle();
    tick();
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
